// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_unit
//  Purpose  : Initiator side of the data-memory port. Takes one load/store
//             request at a time from the MEM stage (valid/ready), drives the
//             memory port, waits a fixed read latency and returns sign/zero
//             extended load data or store completion on a valid/ready
//             response channel. Misaligned addresses and illegal funct3
//             codes are answered with an error response and never reach
//             the memory.
//  Ports    : clk_i, rst_n_i          clock, async active-low reset
//             req_*                   request channel (valid/ready)
//             rsp_*                   response channel (valid/ready)
//             mem_*                   data-memory port (this unit initiates)
//  Revision : 1.0  initial release
// ============================================================================
module mem_access_unit #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    // request channel
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    // response channel
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    // memory port
    output logic                  mem_re_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_r_addr_o,
    output logic [ADDR_WIDTH-1:0] mem_w_addr_o,
    output logic [DATA_WIDTH-1:0] mem_w_data_o,
    output logic [2:0]            mem_mode_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    // Counter value on the last RD cycle is 0; it starts at latency-1.
    localparam logic [3:0] c_LAT_LAST = 4'(MEM_LATENCY - 1);

    state_t                r_state;
    logic                  r_active;      // low while in reset, so ready reads 0
    logic [3:0]            r_lat_cnt;
    logic [2:0]            r_funct3;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;
    logic                  r_mem_re;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_r_addr;
    logic [ADDR_WIDTH-1:0] r_mem_w_addr;
    logic [DATA_WIDTH-1:0] r_mem_w_data;
    logic [2:0]            r_mem_mode;

    logic                  w_accept;
    logic                  w_f3_legal;
    logic                  w_misaligned;
    logic                  w_req_err;
    logic [DATA_WIDTH-1:0] w_load_ext;

    assign req_ready_o  = r_active && (r_state == S_IDLE);
    assign w_accept     = req_valid_i && req_ready_o;

    // Legality of the incoming request, evaluated on the accept edge.
    always_comb begin
        w_f3_legal = 1'b0;
        if (req_we_i) begin
            w_f3_legal = (req_funct3_i == 3'b000) || (req_funct3_i == 3'b001) ||
                         (req_funct3_i == 3'b010);
        end else begin
            w_f3_legal = (req_funct3_i == 3'b000) || (req_funct3_i == 3'b001) ||
                         (req_funct3_i == 3'b010) || (req_funct3_i == 3'b100) ||
                         (req_funct3_i == 3'b101);
        end
    end

    // funct3[1:0] encodes the access size for every legal code.
    assign w_misaligned = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                          ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
    assign w_req_err    = !w_f3_legal || w_misaligned;

    // Extension of the returned data; the addressed byte sits in bits [7:0].
    always_comb begin
        w_load_ext = mem_data_i;
        case (r_funct3)
            3'b000:  w_load_ext = {{(DATA_WIDTH-8){mem_data_i[7]}},   mem_data_i[7:0]};
            3'b100:  w_load_ext = {{(DATA_WIDTH-8){1'b0}},            mem_data_i[7:0]};
            3'b001:  w_load_ext = {{(DATA_WIDTH-16){mem_data_i[15]}}, mem_data_i[15:0]};
            3'b101:  w_load_ext = {{(DATA_WIDTH-16){1'b0}},           mem_data_i[15:0]};
            default: w_load_ext = mem_data_i;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state      <= S_IDLE;
            r_active     <= 1'b0;
            r_lat_cnt    <= 4'd0;
            r_funct3     <= 3'd0;
            r_rsp_valid  <= 1'b0;
            r_rsp_rdata  <= '0;
            r_rsp_err    <= 1'b0;
            r_mem_re     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_r_addr <= '0;
            r_mem_w_addr <= '0;
            r_mem_w_data <= '0;
            r_mem_mode   <= 3'd0;
        end else begin
            r_active <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_funct3 <= req_funct3_i;
                        if (w_req_err) begin
                            // Rejected requests never touch the memory port.
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                        end else if (req_we_i) begin
                            r_state      <= S_WR;
                            r_mem_we     <= 1'b1;
                            r_mem_w_addr <= req_addr_i;
                            r_mem_w_data <= req_wdata_i;
                            r_mem_mode   <= req_funct3_i;
                        end else begin
                            r_state      <= S_RD;
                            r_mem_re     <= 1'b1;
                            r_mem_r_addr <= req_addr_i;
                            r_mem_mode   <= req_funct3_i;
                            r_lat_cnt    <= c_LAT_LAST;
                        end
                    end
                end
                S_RD: begin
                    if (r_lat_cnt == 4'd0) begin
                        r_state     <= S_RESP;
                        r_mem_re    <= 1'b0;
                        r_mem_mode  <= 3'd0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= w_load_ext;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 4'd1;
                    end
                end
                S_WR: begin
                    // The memory commits the write during the single WR cycle.
                    r_state     <= S_RESP;
                    r_mem_we    <= 1'b0;
                    r_mem_mode  <= 3'd0;
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= '0;
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid_o  = r_rsp_valid;
    assign rsp_rdata_o  = r_rsp_rdata;
    assign rsp_err_o    = r_rsp_err;
    assign mem_re_o     = r_mem_re;
    assign mem_we_o     = r_mem_we;
    assign mem_r_addr_o = r_mem_r_addr;
    assign mem_w_addr_o = r_mem_w_addr;
    assign mem_w_data_o = r_mem_w_data;
    assign mem_mode_o   = r_mem_mode;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_unit
//  Purpose  : Self-checking bench for mem_access_unit. Two instances are
//             built: index 0 with MEM_LATENCY=1, index 1 with MEM_LATENCY=3.
//             Each has its own byte-addressed memory model acting as the
//             responder. Expected responses go into a scoreboard queue when
//             a request is driven and are compared when the response shows.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_access_unit;

    localparam int c_LAT0 = 1;
    localparam int c_LAT1 = 3;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_we     [2];
    logic [2:0]  req_funct3 [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        rsp_valid  [2];
    logic        rsp_ready  [2];
    logic [31:0] rsp_rdata  [2];
    logic        rsp_err    [2];
    logic        mem_re     [2];
    logic        mem_we     [2];
    logic [31:0] mem_r_addr [2];
    logic [31:0] mem_w_addr [2];
    logic [31:0] mem_w_data [2];
    logic [2:0]  mem_mode   [2];
    logic [31:0] mem_data   [2];

    logic [7:0]  mem [2][1024];

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(c_LAT0)) u_dut0 (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_we_i(req_we[0]),
        .req_funct3_i(req_funct3[0]), .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
        .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]), .rsp_rdata_o(rsp_rdata[0]),
        .rsp_err_o(rsp_err[0]), .mem_re_o(mem_re[0]), .mem_we_o(mem_we[0]),
        .mem_r_addr_o(mem_r_addr[0]), .mem_w_addr_o(mem_w_addr[0]),
        .mem_w_data_o(mem_w_data[0]), .mem_mode_o(mem_mode[0]), .mem_data_i(mem_data[0])
    );

    mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(c_LAT1)) u_dut1 (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_we_i(req_we[1]),
        .req_funct3_i(req_funct3[1]), .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
        .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]), .rsp_rdata_o(rsp_rdata[1]),
        .rsp_err_o(rsp_err[1]), .mem_re_o(mem_re[1]), .mem_we_o(mem_we[1]),
        .mem_r_addr_o(mem_r_addr[1]), .mem_w_addr_o(mem_w_addr[1]),
        .mem_w_data_o(mem_w_data[1]), .mem_mode_o(mem_mode[1]), .mem_data_i(mem_data[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Responder: writes take effect on the edge that closes the we cycle.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_we[d]) begin
                mem[d][mem_w_addr[d][9:0]] <= mem_w_data[d][7:0];
                if (mem_mode[d][1:0] != 2'b00)
                    mem[d][10'(mem_w_addr[d][9:0] + 10'd1)] <= mem_w_data[d][15:8];
                if (mem_mode[d][1:0] == 2'b10) begin
                    mem[d][10'(mem_w_addr[d][9:0] + 10'd2)] <= mem_w_data[d][23:16];
                    mem[d][10'(mem_w_addr[d][9:0] + 10'd3)] <= mem_w_data[d][31:24];
                end
            end
        end
    end

    always_comb begin
        for (int d = 0; d < 2; d++) begin
            mem_data[d] = {mem[d][10'(mem_r_addr[d][9:0] + 10'd3)],
                           mem[d][10'(mem_r_addr[d][9:0] + 10'd2)],
                           mem[d][10'(mem_r_addr[d][9:0] + 10'd1)],
                           mem[d][mem_r_addr[d][9:0]]};
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_we[d] = 1'b0; req_funct3[d] = 3'd0;
            req_addr[d] = 32'd0; req_wdata[d] = 32'd0; rsp_ready[d] = 1'b1;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({req_ready[d], rsp_valid[d], rsp_err[d], mem_re[d], mem_we[d], mem_mode[d]} !== 8'd0) begin
                errors++;
                $display("FAIL reset_ctrl dut%0d: got %b expected 0", d,
                         {req_ready[d], rsp_valid[d], rsp_err[d], mem_re[d], mem_we[d], mem_mode[d]});
            end
            checks++;
            if ((rsp_rdata[d] | mem_r_addr[d] | mem_w_addr[d] | mem_w_data[d]) !== 32'd0) begin
                errors++;
                $display("FAIL reset_data dut%0d: got nonzero data/address outputs, expected 0", d);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (req_ready[d] !== 1'b1) begin
                errors++;
                $display("FAIL reset_release_ready dut%0d: got %b expected 1", d, req_ready[d]);
            end
        end
    endtask

    // Waits (bounded) at a falling edge until the unit is ready.
    task automatic wait_ready(input int d);
        int n;
        n = 0;
        while (req_ready[d] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req_ready[d] !== 1'b1) begin
            errors++;
            $display("FAIL wait_ready dut%0d: got %b expected 1", d, req_ready[d]);
        end
    endtask

    task automatic run_txn(input int d, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic exp_err, input logic [31:0] exp_rdata,
                           input string name);
        int   lat, resp_at, exp_re, exp_we, cyc, re_c, we_c;
        exp_t e;
        lat     = (d == 0) ? c_LAT0 : c_LAT1;
        resp_at = exp_err ? 1 : (we ? 2 : lat + 1);
        exp_re  = (exp_err || we) ? 0 : lat;
        exp_we  = (!exp_err && we) ? 1 : 0;
        wait_ready(d);
        req_valid[d] = 1'b1; req_we[d] = we; req_funct3[d] = f3;
        req_addr[d] = addr; req_wdata[d] = wdata;
        exp_q.push_back('{exp_err, exp_rdata});
        @(negedge clk);
        req_valid[d] = 1'b0;
        cyc = 1; re_c = 0; we_c = 0;
        while (rsp_valid[d] !== 1'b1 && cyc < 40) begin
            if (mem_re[d] === 1'b1) begin
                re_c++;
                checks++;
                if (mem_r_addr[d] !== addr || mem_mode[d] !== f3) begin
                    errors++;
                    $display("FAIL %s rd_port: addr %h mode %b expected %h %b", name, mem_r_addr[d], mem_mode[d], addr, f3);
                end
            end
            if (mem_we[d] === 1'b1) begin
                we_c++;
                checks++;
                if (mem_w_addr[d] !== addr || mem_w_data[d] !== wdata || mem_mode[d] !== f3) begin
                    errors++;
                    $display("FAIL %s wr_port: addr %h data %h mode %b expected %h %h %b",
                             name, mem_w_addr[d], mem_w_data[d], mem_mode[d], addr, wdata, f3);
                end
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != resp_at) begin
            errors++;
            $display("FAIL %s resp_cycle: got %0d expected %0d", name, cyc, resp_at);
        end
        checks++;
        if (re_c != exp_re || we_c != exp_we) begin
            errors++;
            $display("FAIL %s strobe_cycles: re %0d we %0d expected re %0d we %0d", name, re_c, we_c, exp_re, exp_we);
        end
        checks++;
        if ({mem_re[d], mem_we[d], mem_mode[d]} !== 5'd0) begin
            errors++;
            $display("FAIL %s resp_port_idle: got %b expected 0", name, {mem_re[d], mem_we[d], mem_mode[d]});
        end
        e = exp_q.pop_front();
        checks++;
        if (rsp_err[d] !== e.err || rsp_rdata[d] !== e.rdata) begin
            errors++;
            $display("FAIL %s response: err %b rdata %h expected err %b rdata %h", name, rsp_err[d], rsp_rdata[d], e.err, e.rdata);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1) begin
            errors++;
            $display("FAIL %s return_idle: valid %b ready %b expected 0 1", name, rsp_valid[d], req_ready[d]);
        end
    endtask

    task automatic test_store();
        run_txn(0, 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 1'b0, 32'd0, "sw_100");
        run_txn(0, 1'b1, 3'b010, 32'h200, 32'h8000_80F0, 1'b0, 32'd0, "sw_200");
    endtask

    task automatic test_loads();
        run_txn(0, 1'b0, 3'b000, 32'h200, 32'd0, 1'b0, 32'hFFFF_FFF0, "lb_200");
        run_txn(0, 1'b0, 3'b100, 32'h200, 32'd0, 1'b0, 32'h0000_00F0, "lbu_200");
        run_txn(0, 1'b0, 3'b001, 32'h200, 32'd0, 1'b0, 32'hFFFF_80F0, "lh_200");
        run_txn(0, 1'b0, 3'b101, 32'h202, 32'd0, 1'b0, 32'h0000_8000, "lhu_202");
        run_txn(0, 1'b0, 3'b010, 32'h200, 32'd0, 1'b0, 32'h8000_80F0, "lw_200");
        run_txn(0, 1'b0, 3'b010, 32'h100, 32'd0, 1'b0, 32'hDEAD_BEEF, "lw_100");
    endtask

    task automatic test_errors();
        run_txn(0, 1'b0, 3'b010, 32'h201, 32'd0, 1'b1, 32'd0, "lw_misaligned");
        run_txn(0, 1'b1, 3'b001, 32'h203, 32'h1234, 1'b1, 32'd0, "sh_misaligned");
        run_txn(0, 1'b0, 3'b011, 32'h200, 32'd0, 1'b1, 32'd0, "load_f3_011");
        run_txn(0, 1'b1, 3'b100, 32'h200, 32'h55, 1'b1, 32'd0, "store_f3_100");
        // The rejected store must not have changed memory.
        run_txn(0, 1'b0, 3'b010, 32'h200, 32'd0, 1'b0, 32'h8000_80F0, "lw_after_err");
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   n;
        rsp_ready[0] = 1'b0;
        wait_ready(0);
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_funct3[0] = 3'b010; req_addr[0] = 32'h200;
        exp_q.push_back('{1'b0, 32'h8000_80F0});
        @(negedge clk);
        req_valid[0] = 1'b0;
        n = 0;
        while (rsp_valid[0] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        e = exp_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== e.rdata || rsp_err[0] !== e.err || req_ready[0] !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: valid %b rdata %h err %b ready %b expected 1 %h %b 0",
                         i, rsp_valid[0], rsp_rdata[0], rsp_err[0], req_ready[0], e.rdata, e.err);
            end
            checks++;
            if (mem_re[0] !== 1'b0) begin
                errors++;
                $display("FAIL bp_second_req cycle %0d: mem_re %b expected 0", i, mem_re[0]);
            end
            // A competing request is offered while the response is held.
            req_valid[0] = 1'b1; req_funct3[0] = 3'b000;
            @(negedge clk);
        end
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1 || mem_re[0] !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: valid %b ready %b re %b expected 0 1 0", rsp_valid[0], req_ready[0], mem_re[0]);
        end
    endtask

    task automatic test_latency3();
        run_txn(1, 1'b1, 3'b010, 32'h40, 32'h1234_5678, 1'b0, 32'd0, "l3_sw_40");
        run_txn(1, 1'b0, 3'b010, 32'h40, 32'd0, 1'b0, 32'h1234_5678, "l3_lw_40");
        run_txn(1, 1'b0, 3'b001, 32'h42, 32'd0, 1'b0, 32'h0000_1234, "l3_lh_42");
        run_txn(1, 1'b0, 3'b000, 32'h43, 32'd0, 1'b0, 32'h0000_0012, "l3_lb_43");
    endtask

    task automatic test_reset_mid_rd();
        wait_ready(1);
        req_valid[1] = 1'b1; req_we[1] = 1'b0; req_funct3[1] = 3'b010; req_addr[1] = 32'h40;
        @(negedge clk);
        req_valid[1] = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_re[1] !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_rd_pre: mem_re %b expected 1", mem_re[1]);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (mem_re[1] !== 1'b0 || req_ready[1] !== 1'b0 || rsp_valid[1] !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_rd_async: re %b ready %b valid %b expected 0 0 0", mem_re[1], req_ready[1], rsp_valid[1]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready[1] !== 1'b1) begin
            errors++;
            $display("FAIL rst_release_ready: got %b expected 1", req_ready[1]);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (rsp_valid[1] !== 1'b0 || mem_re[1] !== 1'b0) begin
                errors++;
                $display("FAIL rst_discard cycle %0d: valid %b re %b expected 0 0", i, rsp_valid[1], mem_re[1]);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_store();
        test_loads();
        test_errors();
        test_backpressure();
        test_latency3();
        test_reset_mid_rd();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
